// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the control-signal pipeline of the pipelined core.
//   BR_W         width of the branch-kind field inside the control bundle
//   br_kind_e    branch/jump kind encodings (0 = BR_NONE, so a bubble never
//                branches)
//   *_DEF        default parameter values for the chain and its interface
//   br_taken()   resolves a branch kind against the stage-1 ALU flags
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int BR_W       = 4;
  localparam int BR_LSB_DEF = 0;
  localparam int CTRL_W_DEF = 12;
  localparam int STAGES_DEF = 3;

  typedef enum logic [BR_W-1:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_kind_e;

  // Codes 9..15 are unused; they resolve as not taken.
  function automatic logic br_taken(input logic [BR_W-1:0] kind,
                                    input logic            zero,
                                    input logic            lt,
                                    input logic            ltu);
    logic taken;
    taken = 1'b0;
    case (kind)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = ~zero;
      BR_BLT:  taken = lt;
      BR_BGE:  taken = ~lt;
      BR_BLTU: taken = ltu;
      BR_BGEU: taken = ~ltu;
      BR_JAL:  taken = 1'b1;
      BR_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_chain_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_chain_if
// Bundles every non-clock/reset signal of pipeline_ctrl_chain.
//   ctrl_d  [CTRL_W]         decoded control bundle from Decode
//   valid_d                  Decode holds a real instruction
//   stall   [STAGES+1]       bit0 = Decode, bit s = stage s (1 = hold)
//   flush   [STAGES]         bit s-1 = stage s (1 = load bubble)
//   zero_e, lt_e, ltu_e      stage-1 ALU compare flags
//   ctrl_q  [STAGES*CTRL_W]  stage s bundle at bits [s*CTRL_W-1 -: CTRL_W]
//   valid_q [STAGES]         valid bit per stage
//   pcsrc_e, jalr_e          fetch redirect / JALR target select
//   perf_retired, perf_bubbles, perf_taken [32]  only with PIPE_PERF_EN
// master = the core driving the chain, slave = pipeline_ctrl_chain.
// Optional feature macro: PIPE_PERF_EN.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_chain_if
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int CTRL_W = CTRL_W_DEF
);

  logic [CTRL_W-1:0]        ctrl_d;
  logic                     valid_d;
  logic [STAGES:0]          stall;
  logic [STAGES-1:0]        flush;
  logic                     zero_e;
  logic                     lt_e;
  logic                     ltu_e;
  logic [STAGES*CTRL_W-1:0] ctrl_q;
  logic [STAGES-1:0]        valid_q;
  logic                     pcsrc_e;
  logic                     jalr_e;

`ifdef PIPE_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_bubbles;
  logic [31:0] perf_taken;

  modport master (
    output ctrl_d, valid_d, stall, flush, zero_e, lt_e, ltu_e,
    input  ctrl_q, valid_q, pcsrc_e, jalr_e,
    input  perf_retired, perf_bubbles, perf_taken
  );

  modport slave (
    input  ctrl_d, valid_d, stall, flush, zero_e, lt_e, ltu_e,
    output ctrl_q, valid_q, pcsrc_e, jalr_e,
    output perf_retired, perf_bubbles, perf_taken
  );
`else
  modport master (
    output ctrl_d, valid_d, stall, flush, zero_e, lt_e, ltu_e,
    input  ctrl_q, valid_q, pcsrc_e, jalr_e
  );

  modport slave (
    input  ctrl_d, valid_d, stall, flush, zero_e, lt_e, ltu_e,
    output ctrl_q, valid_q, pcsrc_e, jalr_e
  );
`endif

endinterface

// File: rtl/pipe_ctrl_stage.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_stage
// One register stage of the control pipeline: bundle plus valid bit.
// Per edge, priority flush > hold > auto-bubble > advance.
//   clk, reset         core clock, asynchronous active-low reset
//   flush_i            load a bubble this cycle
//   stall_i            hold this stage
//   stall_up_i         upstream stage is held (insert bubble if not held here)
//   ctrl_i, valid_i    upstream bundle / valid
//   ctrl_o, valid_o    this stage's bundle / valid
//   bubble_o           this stage loads a bubble this cycle (PIPE_PERF_EN only)
// -----------------------------------------------------------------------------
module pipe_ctrl_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH = CTRL_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic             stall_up_i,
  input  logic [WIDTH-1:0] ctrl_i,
  input  logic             valid_i,
`ifdef PIPE_PERF_EN
  output logic             bubble_o,
`endif
  output logic [WIDTH-1:0] ctrl_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic             load_bubble;

  always_comb begin
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    load_bubble = 1'b0;
    if (flush_i) begin
      load_bubble = 1'b1;
    end else if (!stall_i) begin
      // Upstream is frozen while we move on: what it presents is a copy of
      // an instruction it still owns, so take a bubble instead.
      if (stall_up_i) begin
        load_bubble = 1'b1;
      end else begin
        ctrl_d  = ctrl_i;
        valid_d = valid_i;
      end
    end
    if (load_bubble) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign valid_o = valid_q;
`ifdef PIPE_PERF_EN
  assign bubble_o = load_bubble;
`endif

endmodule

// File: rtl/pipeline_ctrl_chain.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_chain
// Carries the decoded control bundle from Decode through STAGES registered
// stages with per-stage stall/flush, automatic bubbles and valid bits, and
// resolves branches/jumps in stage 1.
//   clk     core clock, all state on the rising edge
//   reset   asynchronous, active-low
//   bus     pipeline_ctrl_chain_if.slave (see interface header for signals)
// Parameters: STAGES (>=2), CTRL_W, BR_LSB (LSB of the branch-kind field).
// Optional feature macro: PIPE_PERF_EN adds perf_retired / perf_bubbles /
// perf_taken 32-bit wrapping counters.
// -----------------------------------------------------------------------------
module pipeline_ctrl_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int BR_LSB = BR_LSB_DEF
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_ctrl_chain_if.slave bus
);

  localparam int CHAIN_W = (STAGES + 1) * CTRL_W;

  // Slot 0 of the chain is the Decode input, slot s is stage s.
  logic [CHAIN_W-1:0] chain_ctrl;
  logic [STAGES:0]    chain_valid;
`ifdef PIPE_PERF_EN
  logic [STAGES-1:0]  bubble_load;
`endif

  assign chain_ctrl[CTRL_W-1:0] = bus.ctrl_d;
  assign chain_valid[0]         = bus.valid_d;

  generate
    for (genvar gi = 1; gi <= STAGES; gi++) begin : g_stage
      pipe_ctrl_stage #(
        .WIDTH (CTRL_W)
      ) u_stage (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (bus.flush[gi-1]),
        .stall_i    (bus.stall[gi]),
        .stall_up_i (bus.stall[gi-1]),
        .ctrl_i     (chain_ctrl[gi*CTRL_W-1 -: CTRL_W]),
        .valid_i    (chain_valid[gi-1]),
`ifdef PIPE_PERF_EN
        .bubble_o   (bubble_load[gi-1]),
`endif
        .ctrl_o     (chain_ctrl[(gi+1)*CTRL_W-1 -: CTRL_W]),
        .valid_o    (chain_valid[gi])
      );
    end
  endgenerate

  assign bus.ctrl_q  = chain_ctrl[CHAIN_W-1:CTRL_W];
  assign bus.valid_q = chain_valid[STAGES:1];

  // Stage-1 branch resolution.
  logic [BR_W-1:0] br_field;
  logic            taken;
  logic            pcsrc;

  assign br_field = chain_ctrl[CTRL_W + BR_LSB +: BR_W];
  assign taken    = br_taken(br_field, bus.zero_e, bus.lt_e, bus.ltu_e);
  // Gated by the stall so a held branch redirects only once, in the cycle
  // it actually leaves stage 1.
  assign pcsrc       = chain_valid[1] & taken & ~bus.stall[1];
  assign bus.pcsrc_e = pcsrc;
  assign bus.jalr_e  = chain_valid[1] & (br_field == BR_JALR);

`ifdef PIPE_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_taken_q,   perf_taken_d;

  always_comb begin
    perf_retired_d = perf_retired_q + {31'b0, chain_valid[STAGES] & ~bus.stall[STAGES]};
    perf_bubbles_d = perf_bubbles_q + {31'b0, |bubble_load};
    perf_taken_d   = perf_taken_q   + {31'b0, pcsrc};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_retired_q <= '0;
      perf_bubbles_q <= '0;
      perf_taken_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_bubbles_q <= perf_bubbles_d;
      perf_taken_q   <= perf_taken_d;
    end
  end

  assign bus.perf_retired = perf_retired_q;
  assign bus.perf_bubbles = perf_bubbles_q;
  assign bus.perf_taken   = perf_taken_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_chain.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl_chain
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the stage rules kept in this file.
// Optional feature macro: PIPE_PERF_EN (adds counter checks).
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl_chain;

  localparam int ST = 3;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  pipeline_ctrl_chain_if #(.STAGES(ST), .CTRL_W(CW)) bus ();

  pipeline_ctrl_chain #(
    .STAGES (ST),
    .CTRL_W (CW),
    .BR_LSB (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [CW-1:0] m_ctrl  [1:ST];
  logic          m_valid [1:ST];
`ifdef PIPE_PERF_EN
  logic [31:0] m_retired, m_bubbles, m_taken;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Branch outcome from the kind number: 0 none, 1 BEQ .. 6 BGEU, 7 JAL, 8 JALR.
  function automatic logic ref_taken(input int kind, input logic z, input logic lt, input logic ltu);
    case (kind)
      1:       return z;
      2:       return !z;
      3:       return lt;
      4:       return !lt;
      5:       return ltu;
      6:       return !ltu;
      7, 8:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_pcsrc();
    return m_valid[1] && ref_taken(int'(m_ctrl[1][3:0]), bus.zero_e, bus.lt_e, bus.ltu_e)
           && !bus.stall[1];
  endfunction

  function automatic logic model_jalr();
    return m_valid[1] && (m_ctrl[1][3:0] == 4'd8);
  endfunction

  function automatic logic [ST*CW-1:0] model_vec();
    return {m_ctrl[3], m_ctrl[2], m_ctrl[1]};
  endfunction

  function automatic logic [ST-1:0] model_valid();
    return {m_valid[3], m_valid[2], m_valid[1]};
  endfunction

  task automatic model_reset();
    for (int s = 1; s <= ST; s++) begin
      m_ctrl[2'(s)]  = '0;
      m_valid[2'(s)] = 1'b0;
    end
`ifdef PIPE_PERF_EN
    m_retired = '0;
    m_bubbles = '0;
    m_taken   = '0;
`endif
  endtask

  // One clock edge of the pipeline, using the inputs presented at that edge.
  task automatic model_step();
    logic [CW-1:0] prev_c;
    logic          prev_v;
    logic          hold, up_held, kill;
`ifdef PIPE_PERF_EN
    logic          any_bub;
    any_bub = 1'b0;
    if (m_valid[3] && !bus.stall[3]) m_retired++;
    if (model_pcsrc()) m_taken++;
`endif
    // Walk from the last stage back so each stage still sees its upstream's old value.
    for (int s = ST; s >= 1; s--) begin
      prev_c  = (s == 1) ? bus.ctrl_d  : m_ctrl[2'(s-1)];
      prev_v  = (s == 1) ? bus.valid_d : m_valid[2'(s-1)];
      hold    = bus.stall[2'(s)];
      up_held = bus.stall[2'(s-1)];
      kill    = bus.flush[2'(s-1)] || (!hold && up_held);
      if (kill) begin
        m_ctrl[2'(s)]  = '0;
        m_valid[2'(s)] = 1'b0;
`ifdef PIPE_PERF_EN
        any_bub = 1'b1;
`endif
      end else if (!hold) begin
        m_ctrl[2'(s)]  = prev_c;
        m_valid[2'(s)] = prev_v;
      end
    end
`ifdef PIPE_PERF_EN
    if (any_bub) m_bubbles++;
`endif
  endtask

  task automatic drive_idle();
    bus.ctrl_d  = '0;
    bus.valid_d = 1'b0;
    bus.stall   = '0;
    bus.flush   = '0;
    bus.zero_e  = 1'b0;
    bus.lt_e    = 1'b0;
    bus.ltu_e   = 1'b0;
  endtask

  // One cycle: combinational outputs checked at the negedge, state 1 time unit
  // after the posedge. Returns with time just past the posedge.
  task automatic tick();
    @(negedge clk);
    check("pcsrc_e", 64'(bus.pcsrc_e), 64'(model_pcsrc()));
    check("jalr_e",  64'(bus.jalr_e),  64'(model_jalr()));
    @(posedge clk);
    model_step();
    #1;
    check("ctrl_q",  64'(bus.ctrl_q),  64'(model_vec()));
    check("valid_q", 64'(bus.valid_q), 64'(model_valid()));
`ifdef PIPE_PERF_EN
    check("perf_retired", 64'(bus.perf_retired), 64'(m_retired));
    check("perf_bubbles", 64'(bus.perf_bubbles), 64'(m_bubbles));
    check("perf_taken",   64'(bus.perf_taken),   64'(m_taken));
`endif
    cyc++;
    $display("cyc=%0d ctrl_d=%03h vd=%b stall=%b flush=%b valid_q=%b ctrl_q=%09h",
             cyc, bus.ctrl_d, bus.valid_d, bus.stall, bus.flush, bus.valid_q, bus.ctrl_q);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_async_valid", 64'(bus.valid_q), 64'(0));
    check("rst_async_ctrl",  64'(bus.ctrl_q),  64'(0));
    #1;
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    drive_idle();
    model_reset();
    #12;
    check("rst_valid_q", 64'(bus.valid_q), 64'(0));
    check("rst_ctrl_q",  64'(bus.ctrl_q),  64'(0));
    check("rst_pcsrc",   64'(bus.pcsrc_e), 64'(0));
    check("rst_jalr",    64'(bus.jalr_e),  64'(0));
    #6;
    reset = 1'b1;

    // Straight flow: one instruction walks stage 1, 2, 3.
    bus.ctrl_d = 12'h0A5; bus.valid_d = 1'b1;
    tick();
    check("flow_s1", 64'(bus.ctrl_q[11:0]), 64'(12'h0A5));
    drive_idle();
    tick();
    check("flow_s2", 64'(bus.ctrl_q[23:12]), 64'(12'h0A5));
    tick();
    check("flow_s3", 64'(bus.ctrl_q[35:24]), 64'(12'h0A5));
    check("flow_v3", 64'(bus.valid_q), 64'(3'b100));

    // Stage-1 stall for two cycles: stage 1 holds, stage 2 gets bubbles.
    bus.ctrl_d = 12'h0A0; bus.valid_d = 1'b1;
    tick();
    bus.ctrl_d = 12'h0B0; bus.stall = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_s1_hold", 64'(bus.ctrl_q[11:0]),  64'(12'h0A0));
      check("stall_s2_bub",  64'(bus.ctrl_q[23:12]), 64'(0));
      check("stall_v2_bub",  64'(bus.valid_q[1]),    64'(0));
    end
    bus.stall = '0;
    tick();
    check("unstall_s1", 64'(bus.ctrl_q[11:0]),  64'(12'h0B0));
    check("unstall_s2", 64'(bus.ctrl_q[23:12]), 64'(12'h0A0));

    // Flush beats stall on stage 1; a stalled JAL never redirects.
    bus.ctrl_d = 12'h107; bus.valid_d = 1'b1;
    tick();
    drive_idle();
    #1;
    check("jal_pcsrc", 64'(bus.pcsrc_e), 64'(1));
    bus.stall = 4'b0010; bus.flush = 3'b001;
    #1;
    check("flushstall_pcsrc", 64'(bus.pcsrc_e), 64'(0));
    tick();
    check("flushstall_s1", 64'(bus.ctrl_q[11:0]), 64'(0));
    check("flushstall_v1", 64'(bus.valid_q[0]),   64'(0));
    drive_idle();

    // Branch kinds.
    bus.ctrl_d = 12'h002; bus.valid_d = 1'b1;          // BNE
    tick();
    drive_idle(); bus.zero_e = 1'b0;
    #1;
    check("bne_pcsrc", 64'(bus.pcsrc_e), 64'(1));
    tick();
    bus.ctrl_d = 12'h006; bus.valid_d = 1'b1;          // BGEU
    tick();
    drive_idle(); bus.ltu_e = 1'b1;
    #1;
    check("bgeu_pcsrc", 64'(bus.pcsrc_e), 64'(0));
    tick();
    bus.ctrl_d = 12'h008; bus.valid_d = 1'b1;          // JALR
    tick();
    drive_idle();
    #1;
    check("jalr_pcsrc", 64'(bus.pcsrc_e), 64'(1));
    check("jalr_jalr",  64'(bus.jalr_e),  64'(1));
    tick();

    // Asynchronous reset in the middle of a stream.
    for (int k = 0; k < 3; k++) begin
      bus.ctrl_d = CW'($urandom); bus.valid_d = 1'b1;
      tick();
    end
    drive_idle();
    reset_pulse();
    tick();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      bus.ctrl_d  = CW'($urandom);
      bus.valid_d = 1'($urandom);
      bus.stall   = 4'($urandom) & 4'($urandom) & 4'($urandom);
      bus.flush   = 3'($urandom) & 3'($urandom) & 3'($urandom) & 3'($urandom);
      bus.zero_e  = 1'($urandom);
      bus.lt_e    = 1'($urandom);
      bus.ltu_e   = 1'($urandom);
      tick();
    end
    drive_idle();

`ifdef PIPE_PERF_EN
    // 10 instructions, two of them flushed out of stage 1, one JAL.
    reset_pulse();
    for (int i = 0; i < 10; i++) begin
      bus.ctrl_d  = CW'(((i + 1) << 4) | ((i == 3) ? 7 : 0));
      bus.valid_d = 1'b1;
      bus.flush   = (i == 5 || i == 7) ? 3'b001 : 3'b000;
      tick();
    end
    drive_idle();
    for (int i = 0; i < 5; i++) tick();
    check("perf_retired_total", 64'(bus.perf_retired), 64'(8));
    check("perf_bubbles_total", 64'(bus.perf_bubbles), 64'(2));
    check("perf_taken_total",   64'(bus.perf_taken),   64'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
